riscv_boot_loader: RTL and testbench
====================================

# riscv_boot_loader

Program loader that sits directly upstream of the single-cycle RISC-V core's instruction memory. It accepts a byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit instruction words and writes them sequentially into instruction memory. It then checks a trailing XOR checksum and releases the core's reset only when the image is valid.

## Interface
Parameters:
- IMEM_WORDS, default 64: instruction memory depth in 32-bit words. This is the maximum accepted image length.
- LEN_W, default 16: width of the image-length header field.

Ports:
- clk  in  1  clock.
- areset  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse that begins a load. Honoured in IDLE, RUN and ERROR; ignored in all other states.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write enable, one-cycle pulse.
- imem_addr  out  32  byte address, word aligned (word_idx*4).
- imem_wdata  out  32  assembled instruction word.
- core_rst_n  out  1  active-low reset driven to the core. Reaches the core's areset input.
- busy  out  1  a load is in progress.
- done  out  1  the image loaded and its checksum matched.
- error  out  1  the image was rejected.

## Operation
- A byte is accepted on any cycle with in_valid && in_ready.
- in_ready = 1 only in LEN_LO, LEN_HI, PAYLOAD and CHECK.
- Stream format: LEN[7:0], LEN[15:8], then 4*LEN payload bytes, then one checksum byte.
  - Payload bytes are little-endian per word; the first byte goes to [7:0].
  - The checksum is the XOR of all payload bytes. Header bytes are excluded.
- States:
  - IDLE: start goes to LEN_LO. Clears word_idx, byte_cnt, checksum accumulator, done and error.
  - LEN_LO: an accepted byte goes to LEN_HI.
  - LEN_HI: an accepted byte goes to PAYLOAD when 1 ≤ LEN ≤ IMEM_WORDS. Otherwise it goes to ERROR.
  - PAYLOAD: a 2-bit byte_cnt wraps 3→0.
    - On acceptance with byte_cnt==3, the write is issued and word_idx increments.
    - If that was the last word (word_idx==LEN-1), go to CHECK.
  - CHECK: an accepted byte goes to RUN if it equals the accumulator, otherwise to ERROR.
  - RUN: core_rst_n=1, done=1. start goes to LEN_LO, and core_rst_n drops.
  - ERROR: error=1, core_rst_n=0. start goes to LEN_LO.
- busy = 1 in LEN_LO through CHECK.
- Memory contents already written are never erased on error or reset. The core simply stays in reset.
- Length comparison is done at LEN_W bits. word_idx is wide enough to hold IMEM_WORDS.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, error=0. The state register returns to IDLE.
- Reset has priority over every other input, including during PAYLOAD. Outputs take their reset values at the first clk edge with areset=0.
- imem_we pulses the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are valid in that same cycle.
- The last word's write occurs in the first CHECK cycle, before the checksum decision.
- core_rst_n and done rise the cycle after the matching checksum byte is accepted.
- error rises the cycle after the bad LEN_HI byte or the bad checksum byte is accepted.
- start in RUN drops core_rst_n and done in the next cycle.
- Back-to-back bytes (in_valid held high) are accepted every cycle with no bubbles. Gaps in in_valid stall the FSM without side effects.
- start while busy is ignored.

## Structure
- Package riscv_boot_pkg holds:
  - the boot_state_t enum (IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, RUN, ERROR);
  - the default LEN_W;
  - the byte-lane count constant BYTES_PER_WORD=4.
- One sub-module, boot_word_packer, contains the byte shift register and byte_cnt. It emits word_valid/word for the FSM.
- The top contains the FSM, length check, word_idx/address counter, checksum accumulator and output registers.

## Test plan
- Nominal load, IMEM_WORDS=64:
  - Stimulus: start, then bytes 02 00, 13 05 50 00, 33 06 B5 00, C6.
  - Required: writes (0x0, 0x00500513) then (0x4, 0x00B50633), in_ready drops, then core_rst_n=1 and done=1.
- Same stream with checksum C7 → both writes still occur, error=1, core_rst_n stays 0, done=0.
- Header 00 00 → error=1 the cycle after the 2nd byte, no imem_we, in_ready=0.
- Header 41 00 → ERROR. Header 40 00 with 256 payload bytes and a correct checksum → 64 writes, last at addr 0xFC, then RUN.
- Nominal stream with in_valid dropped on random cycles → identical writes and final state.
- Reset and reload:
  - areset=0 after 6 payload bytes → all outputs at reset values next edge.
  - A fresh start plus the nominal stream then yields RUN.
  - start in RUN → core_rst_n=0 next cycle and a reload proceeds.

Source files
------------

// File: rtl/riscv_boot_pkg.sv
// Shared types and constants for the RISC-V boot loader.
package riscv_boot_pkg;

  localparam int unsigned LEN_W_DEFAULT  = 16;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words.
module boot_word_packer
  import riscv_boot_pkg::*;
(
  input  logic        clk,
  input  logic        areset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  output logic        o_word_valid_c,
  output logic [31:0] o_word_c
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] r_byte_cnt;
  logic [23:0]      r_shift;

  // Only the three earlier bytes are held; the fourth completes the word directly.
  always_ff @(posedge clk) begin
    if (!areset) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      r_shift    <= {i_data, r_shift[23:8]};
    end
  end

  assign o_word_valid_c = i_accept && (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word_c       = {i_data, r_shift};

endmodule

// File: rtl/riscv_boot_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory
// and releases the core's reset only after a valid load.
module riscv_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned LEN_W      = LEN_W_DEFAULT
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(IMEM_WORDS + 1);

  boot_state_t      r_state;
  boot_state_t      w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [IDX_W-1:0] r_word_idx;
  logic [7:0]       r_csum;

  logic        r_in_ready, r_imem_we, r_core_rst_n, r_busy, r_done, r_error;
  logic [31:0] r_imem_addr, r_imem_wdata;
  logic        w_in_ready, w_core_rst_n, w_busy, w_done, w_error;

  logic             w_accept, w_pay_accept, w_start_ok, w_clear;
  logic [LEN_W-1:0] w_len;
  logic             w_len_ok, w_last;
  logic             w_word_valid;
  logic [31:0]      w_word;

  assign w_accept     = in_valid && r_in_ready;
  assign w_pay_accept = w_accept && (r_state == PAYLOAD);
  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == RUN) || (r_state == ERROR));
  assign w_clear      = (r_state == IDLE) || w_start_ok;
  assign w_len        = LEN_W'({in_data, r_len[7:0]});
  assign w_len_ok     = (w_len != '0) && (w_len <= LEN_W'(IMEM_WORDS));
  assign w_last       = (LEN_W'(r_word_idx) == (r_len - LEN_W'(1)));

  boot_word_packer u_packer (
    .clk            (clk),
    .areset         (areset),
    .i_clear        (w_clear),
    .i_accept       (w_pay_accept),
    .i_data         (in_data),
    .o_word_valid_c (w_word_valid),
    .o_word_c       (w_word)
  );

  always_ff @(posedge clk) begin
    if (!areset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LEN_LO;
      LEN_LO:  if (w_accept) w_state_nxt = LEN_HI;
      LEN_HI:  if (w_accept) w_state_nxt = w_len_ok ? PAYLOAD : ERROR;
      PAYLOAD: if (w_word_valid && w_last) w_state_nxt = CHECK;
      CHECK:   if (w_accept) w_state_nxt = (in_data == r_csum) ? RUN : ERROR;
      RUN:     if (start) w_state_nxt = LEN_LO;
      ERROR:   if (start) w_state_nxt = LEN_LO;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_core_rst_n = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    case (w_state_nxt)
      LEN_LO, LEN_HI, PAYLOAD, CHECK: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      RUN: begin
        w_core_rst_n = 1'b1;
        w_done       = 1'b1;
      end
      ERROR:   w_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_in_ready   <= w_in_ready;
      r_busy       <= w_busy;
      r_core_rst_n <= w_core_rst_n;
      r_done       <= w_done;
      r_error      <= w_error;
    end
  end

  // Header capture, checksum accumulation and memory write port.
  always_ff @(posedge clk) begin
    if (!areset) begin
      r_len        <= '0;
      r_word_idx   <= '0;
      r_csum       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= 1'b0;
      if (w_clear) begin
        r_word_idx <= '0;
        r_csum     <= '0;
      end else begin
        if (w_accept && (r_state == LEN_LO)) r_len <= LEN_W'(in_data);
        if (w_accept && (r_state == LEN_HI)) r_len <= w_len;
        if (w_pay_accept) r_csum <= r_csum ^ in_data;
        if (w_word_valid) begin
          r_imem_we    <= 1'b1;
          r_imem_addr  <= 32'({r_word_idx, 2'b00});
          r_imem_wdata <= w_word;
          r_word_idx   <= r_word_idx + IDX_W'(1);
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_rst_n = r_core_rst_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Directed bench for riscv_boot_loader: nominal, bad checksum, length limits,
// stalled stream, reset mid-load and reload.
module tb_riscv_boot_loader;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always #5 clk = ~clk;

  riscv_boot_loader #(.IMEM_WORDS(64), .LEN_W(16)) dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_nom(input int first, input int last, input logic [7:0] cs, input int gapmax);
    logic [7:0] s[11];
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h33, 8'h06, 8'hB5, 8'h00, cs};
    for (int i = first; i <= last; i++)
      send_byte(s[i], (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0)));
  endtask

  task automatic check_nom_writes();
    chk("wr_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("wr0_addr", wr_addr[0], 32'h0000_0000);
      chk("wr0_data", wr_data[0], 32'h0050_0513);
      chk("wr1_addr", wr_addr[1], 32'h0000_0004);
      chk("wr1_data", wr_data[1], 32'h00B5_0633);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_imem_we",    32'(imem_we),    32'd0);
    chk("rst_imem_addr",  imem_addr,       32'd0);
    chk("rst_imem_wdata", imem_wdata,      32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_error",      32'(error),      32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [31:0] lastw;

    areset   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    areset = 1'b1;
    @(negedge clk);

    // Nominal two-word image
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(in_ready), 32'd1);
    send_nom(0, 9, 8'hC6, 0);
    chk("t1_last_we", 32'(imem_we), 32'd1);
    chk("t1_last_addr", imem_addr, 32'h4);
    chk("t1_last_data", imem_wdata, 32'h00B5_0633);
    chk("t1_check_ready", 32'(in_ready), 32'd1);
    chk("t1_check_rst", 32'(core_rst_n), 32'd0);
    send_nom(10, 10, 8'hC6, 0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_ready_end", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_nom_writes();

    // Start from RUN, then a bad checksum
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    chk("t2_rst_drop", 32'(core_rst_n), 32'd0);
    chk("t2_done_drop", 32'(done), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    send_nom(0, 10, 8'hC7, 0);
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("t2_done", 32'(done), 32'd0);
    chk("t2_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_nom_writes();

    // Zero length header
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    chk("t3_error_clr", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    chk("t3_no_err_yet", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_ready", 32'(in_ready), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_no_writes", 32'(wr_addr.size()), 32'd0);

    // Length one past the memory
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_core_rst_n", 32'(core_rst_n), 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_no_writes", 32'(wr_addr.size()), 32'd0);

    // Full-memory image of 64 words
    pulse_start();
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    chk("t5_len_ok", 32'(error), 32'd0);
    cs = 8'h00;
    lastw = 32'h0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i * 7 + 3);
      cs = cs ^ b;
      if (i >= 252) lastw[8*(i-252) +: 8] = b;
      send_byte(b, 0);
    end
    send_byte(cs, 0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_core_rst_n", 32'(core_rst_n), 32'd1);
    @(negedge clk);
    chk("t5_wr_count", 32'(wr_addr.size()), 32'd64);
    if (wr_addr.size() == 64) begin
      chk("t5_first_data", wr_data[0], 32'h18_11_0A_03);
      chk("t5_last_addr", wr_addr[63], 32'hFC);
      chk("t5_last_data", wr_data[63], lastw);
    end

    // Nominal image with gaps in in_valid
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_nom(0, 10, 8'hC6, 2);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_core_rst_n", 32'(core_rst_n), 32'd1);
    @(negedge clk);
    check_nom_writes();

    // Reset after six payload bytes, then reload
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_nom(0, 7, 8'hC6, 0);
    areset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    areset = 1'b1;
    @(negedge clk);
    chk("t7_idle_busy", 32'(busy), 32'd0);
    chk("t7_partial_writes", 32'(wr_addr.size()), 32'd1);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_nom(0, 10, 8'hC6, 0);
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_core_rst_n", 32'(core_rst_n), 32'd1);
    @(negedge clk);
    check_nom_writes();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
